seg7_scroll_bank: RTL and testbench
===================================

Name: seg7_scroll_bank

Overview:
- Parametrised successor to the fixed 6-digit seven-segment register bank.
- Holds NDIG segment-pattern registers, written one at a time through an address/select port.
- Optionally rotates the displayed message left or right at a programmable tick rate to produce marquee scrolling.
- Sits between the processor-side parallel port and the board HEX displays.

Parameters:
- NDIG, 6, number of display digits (2..16).
- SEG_W, 7, segment bits per digit.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NDIG.
- TICK_DIV, 25000000, clock cycles per scroll step (>= 2).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Data  in  SEG_W  segment pattern to write.
- Addr  in  ADDR_W  target digit; 0 is the rightmost digit.
- Sel  in  1  write strobe; one write per cycle while high.
- Mode  in  1  0 = static, 1 = scroll.
- Dir  in  1  0 = rotate left (digit i moves to i+1), 1 = rotate right.
- HEX  out  NDIG*SEG_W  concatenated digit patterns; digit i occupies bits [i*SEG_W +: SEG_W].
- Step  out  1  one-cycle pulse in the cycle a rotation is committed.
- Pos  out  ADDR_W  rotation offset modulo NDIG since last reset.

Behaviour:
- Reset (synchronous, active-high): all digit registers = 0, HEX = 0, Step = 0, Pos = 0, tick counter = 0, FSM = STATIC.
- Reset has priority over every other input, including mid-scroll and same-cycle writes.
- Write: if Sel=1 and Addr < NDIG, the digit at Addr takes Data at the next edge; HEX reflects it one cycle later. Addr >= NDIG is ignored with no side effects.
- FSM states: STATIC, SCROLL.
  - STATIC -> SCROLL when Mode=1.
  - SCROLL -> STATIC when Mode=0.
  - Entering either state clears the tick counter.
- Tick counter: counts 0..TICK_DIV-1 in SCROLL only and holds 0 in STATIC. When it reaches TICK_DIV-1, the next edge wraps it to 0 and commits a rotation.
- Step is asserted in the cycle after the rotation edge, aligned with the updated HEX.
- First rotation after entering SCROLL occurs exactly TICK_DIV cycles after the edge that registered the state change.
- Rotate left: new[i] = old[i-1], new[0] = old[NDIG-1]. Pos increments modulo NDIG.
- Rotate right: new[i] = old[i+1], new[NDIG-1] = old[0]. Pos decrements modulo NDIG (0 wraps to NDIG-1).
- Dir is sampled on the rotation edge; changing Dir mid-count does not reset the counter.
- Write and rotation in the same cycle: rotation is applied first, then the write overwrites position Addr of the rotated image. Net result: digit Addr = Data, all others rotated.
- Mode falling in the same cycle the counter would wrap: no rotation occurs and the FSM goes to STATIC.
- NDIG = 1 is not supported; with NDIG >= 2 Pos always stays within 0..NDIG-1.

Optional Feature:
- Macro: SEG7_SCROLL_ACTIVE_LOW_EN
- Defined: HEX is the bitwise inverse of the stored patterns, for active-low board segments. After reset HEX = all ones (all segments dark).
- Not defined: HEX equals the stored patterns directly (active-high).
- Stored register contents, Step and Pos are identical in both builds.

Test Plan:
- Reset then write sequence: NDIG=6, TICK_DIV=4, Mode=0; write Addr0..5 = 7'h01..7'h06 -> HEX = {06,05,04,03,02,01}, Step never pulses, Pos = 0.
- Scroll left: from that state set Mode=1, Dir=0 -> Step pulses every 4 cycles. After the first step HEX = {05,04,03,02,01,06}, Pos = 1. After 6 steps HEX returns to the original and Pos = 0.
- Scroll right with wrap: Dir=1 from Pos=0 -> first step gives HEX = {01,06,05,04,03,02}, Pos = 5.
- Write collides with step: Sel=1, Addr=0, Data=7'h7F in the rotation cycle -> digit0 = 7F, digits 1..5 hold the rotated values.
- Illegal address and mid-scroll reset: Sel=1, Addr=9 -> no change. Then Reset=1 mid-count -> next cycle HEX = 0 (all ones with SEG7_SCROLL_ACTIVE_LOW_EN), Pos = 0, and no Step for TICK_DIV cycles after Reset deasserts with Mode=1.
- Mode drop at wrap: Mode=0 in the cycle the counter equals 3 -> no rotation, HEX unchanged, FSM is STATIC.

Source files
------------

// File: rtl/seg7_scroll_bank.sv
// NDIG-digit seven-segment register bank with optional marquee rotation.
// Build option: define SEG7_SCROLL_ACTIVE_LOW_EN to drive HEX inverted for active-low segments.
module seg7_scroll_bank #(
   parameter int NDIG     = 6,
   parameter int SEG_W    = 7,
   parameter int ADDR_W   = 4,
   parameter int TICK_DIV = 25000000
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [SEG_W-1:0]        Data,
   input  logic [ADDR_W-1:0]       Addr,
   input  logic                    Sel,
   input  logic                    Mode,
   input  logic                    Dir,
   output logic [NDIG*SEG_W-1:0]   HEX,
   output logic                    Step,
   output logic [ADDR_W-1:0]       Pos
);

   localparam int                W        = NDIG * SEG_W;
   localparam int                CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] POS_LAST = ADDR_W'(NDIG - 1);

   typedef enum logic {STATIC, SCROLL} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [W-1:0]      store, store_next;
   logic [ADDR_W-1:0] pos_next;
   logic              rotate;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= STATIC;
         cnt   <= '0;
         store <= '0;
         Step  <= 1'b0;
         Pos   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         store <= store_next;
         Step  <= rotate;
         Pos   <= pos_next;
      end
   end

   // A Mode drop on the wrap cycle wins over the rotation.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      rotate     = 1'b0;
      case (state)
         STATIC: begin
            if (Mode) state_next = SCROLL;
         end
         SCROLL: begin
            if (!Mode) begin
               state_next = STATIC;
            end else if (cnt == CNT_LAST) begin
               rotate = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = STATIC;
      endcase
   end

   // Rotation is applied first so a same-cycle write lands on the rotated image.
   always_comb begin
      store_next = store;
      if (rotate) begin
         if (Dir) store_next = {store[SEG_W-1:0], store[W-1:SEG_W]};
         else     store_next = {store[W-SEG_W-1:0], store[W-1 -: SEG_W]};
      end
      if (Sel) begin
         for (int unsigned i = 0; i < NDIG; i++) begin
            if (Addr == ADDR_W'(i)) store_next[i*SEG_W +: SEG_W] = Data;
         end
      end
   end

   always_comb begin
      pos_next = Pos;
      if (rotate) begin
         if (Dir) pos_next = (Pos == '0)       ? POS_LAST : Pos - ADDR_W'(1);
         else     pos_next = (Pos == POS_LAST) ? '0       : Pos + ADDR_W'(1);
      end
   end

`ifdef SEG7_SCROLL_ACTIVE_LOW_EN
   assign HEX = ~store;
`else
   assign HEX = store;
`endif

endmodule

// File: tb/tb_seg7_scroll_bank.sv
// Directed self-checking bench for seg7_scroll_bank (NDIG=6, TICK_DIV=4).
module tb_seg7_scroll_bank;

   localparam int NDIG = 6;
   localparam int SEG_W = 7;
   localparam int ADDR_W = 4;
   localparam int TICK_DIV = 4;

   logic                  Clock = 1'b0;
   logic                  Reset = 1'b1;
   logic [SEG_W-1:0]      Data  = '0;
   logic [ADDR_W-1:0]     Addr  = '0;
   logic                  Sel   = 1'b0;
   logic                  Mode  = 1'b0;
   logic                  Dir   = 1'b0;
   logic [NDIG*SEG_W-1:0] HEX;
   logic                  Step;
   logic [ADDR_W-1:0]     Pos;

   int checks = 0;
   int errors = 0;
   int n;
   int pulses;
   logic [NDIG*SEG_W-1:0] orig;

   seg7_scroll_bank #(.NDIG(NDIG), .SEG_W(SEG_W), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
      .Clock(Clock), .Reset(Reset), .Data(Data), .Addr(Addr), .Sel(Sel),
      .Mode(Mode), .Dir(Dir), .HEX(HEX), .Step(Step), .Pos(Pos)
   );

   always #5 Clock = ~Clock;

   function automatic logic [NDIG*SEG_W-1:0] hx(input logic [NDIG*SEG_W-1:0] v);
`ifdef SEG7_SCROLL_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Ticks until Step is seen; returns the number of edges taken (50 on timeout).
   task automatic wait_step(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!Step && cnt < 50);
   endtask

   task automatic load_123456();
      for (int a = 0; a < NDIG; a++) begin
         Sel = 1'b1; Addr = ADDR_W'(a); Data = SEG_W'(a + 1);
         tick();
         check("write_no_step", 64'(Step), 64'd0);
      end
      Sel = 1'b0;
   endtask

   initial begin
      orig = {7'h06, 7'h05, 7'h04, 7'h03, 7'h02, 7'h01};

      // reset state
      tick(); tick();
      Reset = 1'b0;
      check("reset_hex", 64'(HEX), 64'(hx('0)));
      check("reset_step", 64'(Step), 64'd0);
      check("reset_pos", 64'(Pos), 64'd0);

      // static writes
      load_123456();
      tick();
      check("write_hex", 64'(HEX), 64'(hx(orig)));
      check("write_pos", 64'(Pos), 64'd0);

      // scroll left: first step TICK_DIV edges after the SCROLL-registering edge
      Mode = 1'b1; Dir = 1'b0;
      wait_step(n);
      check("left_first_latency", 64'(n), 64'd5);
      check("left1_hex", 64'(HEX), 64'(hx({7'h05, 7'h04, 7'h03, 7'h02, 7'h01, 7'h06})));
      check("left1_pos", 64'(Pos), 64'd1);
      tick();
      check("step_one_cycle", 64'(Step), 64'd0);
      for (int s = 2; s <= NDIG; s++) begin
         wait_step(n);
         check("left_period", 64'(n), 64'(s == 2 ? 3 : 4));
      end
      check("left6_hex", 64'(HEX), 64'(hx(orig)));
      check("left6_pos", 64'(Pos), 64'd0);

      // scroll right with Pos wrap from 0
      Dir = 1'b1;
      wait_step(n);
      check("right_period", 64'(n), 64'd4);
      check("right1_hex", 64'(HEX), 64'(hx({7'h01, 7'h06, 7'h05, 7'h04, 7'h03, 7'h02})));
      check("right1_pos", 64'(Pos), 64'd5);

      // write collides with rotation edge
      tick(); tick(); tick();
      check("pre_collide_no_step", 64'(Step), 64'd0);
      Sel = 1'b1; Addr = 4'd0; Data = 7'h7F;
      tick();
      Sel = 1'b0;
      check("collide_step", 64'(Step), 64'd1);
      check("collide_hex", 64'(HEX), 64'(hx({7'h02, 7'h01, 7'h06, 7'h05, 7'h04, 7'h7F})));
      check("collide_pos", 64'(Pos), 64'd4);

      // illegal address ignored
      Sel = 1'b1; Addr = 4'd9; Data = 7'h55;
      tick();
      Sel = 1'b0;
      check("illegal_addr_hex", 64'(HEX), 64'(hx({7'h02, 7'h01, 7'h06, 7'h05, 7'h04, 7'h7F})));
      check("illegal_addr_pos", 64'(Pos), 64'd4);

      // reset mid-count with a same-cycle write
      Reset = 1'b1; Sel = 1'b1; Addr = 4'd2; Data = 7'h33;
      tick();
      Sel = 1'b0;
      check("midreset_hex", 64'(HEX), 64'(hx('0)));
      check("midreset_pos", 64'(Pos), 64'd0);
      check("midreset_step", 64'(Step), 64'd0);
      Reset = 1'b0; Dir = 1'b0;
      wait_step(n);
      check("post_reset_latency", 64'(n), 64'd5);
      check("post_reset_pos", 64'(Pos), 64'd1);

      // back to static, reload, then drop Mode on the wrap cycle
      Mode = 1'b0;
      tick(); tick();
      load_123456();
      tick();
      check("reload_hex", 64'(HEX), 64'(hx(orig)));
      Mode = 1'b1;
      wait_step(n);
      check("rescroll_latency", 64'(n), 64'd5);
      check("rescroll_pos", 64'(Pos), 64'd2);
      tick(); tick(); tick();
      Mode = 1'b0;
      tick();
      check("drop_no_step", 64'(Step), 64'd0);
      check("drop_hex", 64'(HEX), 64'(hx({7'h05, 7'h04, 7'h03, 7'h02, 7'h01, 7'h06})));
      check("drop_pos", 64'(Pos), 64'd2);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (Step) pulses++;
      end
      check("static_no_pulses", 64'(pulses), 64'd0);
      check("static_hex_hold", 64'(HEX), 64'(hx({7'h05, 7'h04, 7'h03, 7'h02, 7'h01, 7'h06})));

      // counter restarted from 0 after re-entry
      Mode = 1'b1;
      wait_step(n);
      check("reentry_latency", 64'(n), 64'd5);
      check("reentry_pos", 64'(Pos), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
